// File: rtl/cdi_pkg.sv
// Shared CD-i core definitions: NVRAM geometry and the save/restore state encoding.
package cdi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_XFER,
        WR_REQ,
        WR_XFER
    } nvram_sync_state_e;

    localparam int NVRAM_BYTES      = 8192;
    localparam int SD_BLOCK_BYTES   = 512;
    localparam int NVRAM_ADDR_BITS  = $clog2(NVRAM_BYTES);
    localparam int BLOCK_ADDR_BITS  = $clog2(SD_BLOCK_BYTES);
    localparam int BLOCK_INDEX_BITS = NVRAM_ADDR_BITS - BLOCK_ADDR_BITS;

    // The save image holds NVRAM blocks starting at LBA 0, so the LBA is the block index.
    function automatic logic [31:0] block_to_lba(input logic [BLOCK_INDEX_BITS-1:0] blk);
        return {{(32 - BLOCK_INDEX_BITS){1'b0}}, blk};
    endfunction

endpackage

// File: rtl/nvram_dirty_tracker.sv
// Tracks unsaved CPU NVRAM writes and signals when the quiet period before autosave has elapsed.
module nvram_dirty_tracker #(
    parameter int DEBOUNCE_CYCLES = 30000000
) (
    input  logic clk30,
    input  logic reset,
    input  logic changed,
    input  logic clear,
    output logic dirty,
    output logic autosave_due
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // A fresh CPU write outranks a clear so a change landing on the save launch is not lost.
    always_ff @(posedge clk30) begin
        if (reset) begin
            dirty <= 1'b0;
            count <= '0;
        end else if (changed) begin
            dirty <= 1'b1;
            count <= '0;
        end else if (clear) begin
            dirty <= 1'b0;
            count <= '0;
        end else if (dirty && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign autosave_due = dirty && (count == CNT_MAX);

endmodule

// File: rtl/nvram_save_sync.sv
// Restores the CD-i NVRAM from the mounted save image and writes it back through
// the hps_io SD-block interface when the CPU has modified it.
module nvram_save_sync
    import cdi_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 30000000,
    parameter int NUM_BLOCKS      = 16
) (
    input  logic        clk30,
    input  logic        reset,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic [63:0] img_size,
    input  logic        autosave_en,
    input  logic        save_req,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,
    output logic [12:0] nvram_backup_restore_adr,
    output logic [7:0]  nvram_restore_data,
    output logic        nvram_restore_write,
    input  logic [7:0]  nvram_backup_data,
    input  logic        nvram_cpu_changed,
    output logic        nvram_allow_cpu_access,
    output logic        busy
);

    localparam logic [BLOCK_INDEX_BITS-1:0] LAST_BLK = BLOCK_INDEX_BITS'(NUM_BLOCKS - 1);

    nvram_sync_state_e state, state_next;
    logic [BLOCK_INDEX_BITS-1:0] blk, blk_next;

    logic ack_q;
    logic ack_rise;
    logic ack_fall;
    logic mounted;
    logic writable;
    logic pending_mount;
    logic mount_consume;
    logic dirty;
    logic dirty_clear;
    logic autosave_due;
    logic save_trigger;

    nvram_dirty_tracker #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_dirty (
        .clk30       (clk30),
        .reset       (reset),
        .changed     (nvram_cpu_changed),
        .clear       (dirty_clear),
        .dirty       (dirty),
        .autosave_due(autosave_due)
    );

    // Edges are taken against the previous sample so a stale ack left high on entry
    // to a request state has to drop and rise again before it counts.
    assign ack_rise = sd_ack && !ack_q;
    assign ack_fall = !sd_ack && ack_q;

    assign save_trigger = save_req || (autosave_en && autosave_due);

    always_ff @(posedge clk30) begin
        if (reset) begin
            state <= IDLE;
            blk   <= '0;
            ack_q <= 1'b0;
        end else begin
            state <= state_next;
            blk   <= blk_next;
            ack_q <= sd_ack;
        end
    end

    // A mount notification arriving in the same cycle as the consume must survive.
    always_ff @(posedge clk30) begin
        if (reset) begin
            mounted       <= 1'b0;
            writable      <= 1'b0;
            pending_mount <= 1'b0;
        end else begin
            if (mount_consume) begin
                pending_mount <= 1'b0;
            end
            if (img_mounted) begin
                mounted       <= (img_size != 64'd0);
                writable      <= !img_readonly;
                pending_mount <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state;
        blk_next      = blk;
        dirty_clear   = 1'b0;
        mount_consume = 1'b0;
        case (state)
            IDLE: begin
                if (pending_mount && mounted) begin
                    state_next    = RD_REQ;
                    blk_next      = '0;
                    mount_consume = 1'b1;
                end else if (pending_mount) begin
                    mount_consume = 1'b1;
                    dirty_clear   = 1'b1;
                end else if (mounted && writable && dirty && save_trigger) begin
                    state_next  = WR_REQ;
                    blk_next    = '0;
                    dirty_clear = 1'b1;
                end
            end
            RD_REQ: begin
                if (ack_rise) begin
                    state_next = RD_XFER;
                end
            end
            // A completed restore matches the image, so nothing is left to save.
            RD_XFER: begin
                if (ack_fall) begin
                    if (blk == LAST_BLK) begin
                        state_next  = IDLE;
                        dirty_clear = 1'b1;
                    end else begin
                        state_next = RD_REQ;
                        blk_next   = blk + 1'b1;
                    end
                end
            end
            WR_REQ: begin
                if (ack_rise) begin
                    state_next = WR_XFER;
                end
            end
            WR_XFER: begin
                if (ack_fall) begin
                    if (blk == LAST_BLK) begin
                        state_next = IDLE;
                    end else begin
                        state_next = WR_REQ;
                        blk_next   = blk + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign sd_rd  = (state == RD_REQ);
    assign sd_wr  = (state == WR_REQ);
    assign sd_lba = block_to_lba(blk);
    assign busy   = (state != IDLE);

    assign nvram_allow_cpu_access = !((state == RD_REQ) || (state == RD_XFER));

    // NVRAM port B follows the HPS buffer index directly; hps_io absorbs the read latency.
    assign nvram_backup_restore_adr = {blk, sd_buff_addr};
    assign nvram_restore_data       = sd_buff_dout;
    assign nvram_restore_write      = sd_buff_wr && sd_ack && (state == RD_XFER);
    assign sd_buff_din              = nvram_backup_data;

endmodule

// File: tb/tb_nvram_save_sync.sv
// Scoreboard bench for nvram_save_sync with an HPS block-server model and an NVRAM model.
`timescale 1ns/1ps
module tb_nvram_save_sync;

    localparam int DEB = 100;

    logic        clk30 = 1'b0;
    logic        reset;
    logic        img_mounted;
    logic        img_readonly;
    logic [63:0] img_size;
    logic        autosave_en;
    logic        save_req;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic [12:0] nvram_backup_restore_adr;
    logic [7:0]  nvram_restore_data;
    logic        nvram_restore_write;
    logic [7:0]  nvram_backup_data;
    logic        nvram_cpu_changed;
    logic        nvram_allow_cpu_access;
    logic        busy;

    always #5 clk30 = ~clk30;

    nvram_save_sync #(
        .DEBOUNCE_CYCLES(DEB),
        .NUM_BLOCKS     (16)
    ) dut (
        .clk30                   (clk30),
        .reset                   (reset),
        .img_mounted             (img_mounted),
        .img_readonly            (img_readonly),
        .img_size                (img_size),
        .autosave_en             (autosave_en),
        .save_req                (save_req),
        .sd_lba                  (sd_lba),
        .sd_rd                   (sd_rd),
        .sd_wr                   (sd_wr),
        .sd_ack                  (sd_ack),
        .sd_buff_addr            (sd_buff_addr),
        .sd_buff_dout            (sd_buff_dout),
        .sd_buff_wr              (sd_buff_wr),
        .sd_buff_din             (sd_buff_din),
        .nvram_backup_restore_adr(nvram_backup_restore_adr),
        .nvram_restore_data      (nvram_restore_data),
        .nvram_restore_write     (nvram_restore_write),
        .nvram_backup_data       (nvram_backup_data),
        .nvram_cpu_changed       (nvram_cpu_changed),
        .nvram_allow_cpu_access  (nvram_allow_cpu_access),
        .busy                    (busy)
    );

    typedef struct {
        bit wr;
        int lba;
        int cyc;
    } req_t;

    req_t req_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   req_seen    = 0;
    int   wr_seen     = 0;
    int   last_ack_fall = 0;
    bit   hps_active  = 1'b0;

    logic [7:0] nvram [0:8191];

    always @(posedge clk30) cyc <= cyc + 1;

    // Dual-port NVRAM, port B side: synchronous write, one-cycle read latency.
    always @(posedge clk30) begin
        if (nvram_restore_write) nvram[nvram_backup_restore_adr] <= nvram_restore_data;
        nvram_backup_data <= nvram[nvram_backup_restore_adr];
    end

    function automatic logic [7:0] exp_byte(input logic [3:0] lba, input int idx);
        return 8'(idx) ^ {4'h0, lba};
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic push_reqs(input bit wr, input int first, input int last, input int first_cyc);
        for (int i = first; i <= last; i++) begin
            req_t r;
            r.wr  = wr;
            r.lba = i;
            r.cyc = (i == first) ? first_cyc : -1;
            req_q.push_back(r);
        end
    endtask

    // HPS side of one block transfer: ack, stream 512 bytes, drop ack.
    task automatic serve_block(input bit wr, input logic [3:0] lba);
        int bad = 0;
        hps_active = 1'b1;
        repeat (2) @(negedge clk30);
        sd_ack = 1'b1;
        repeat (2) @(negedge clk30);
        for (int i = 0; i < 512; i++) begin
            sd_buff_addr = 9'(i);
            if (!wr) begin
                sd_buff_dout = exp_byte(lba, i);
                sd_buff_wr   = 1'b1;
            end
            @(negedge clk30);
            if (wr && (sd_buff_din !== exp_byte(lba, i))) bad++;
        end
        sd_buff_wr = 1'b0;
        @(negedge clk30);
        sd_ack        = 1'b0;
        last_ack_fall = cyc;
        if (wr) check_output($sformatf("wr_data_blk%0d", lba), 64'(bad), 64'd0);
        hps_active = 1'b0;
    endtask

    initial begin
        sd_ack       = 1'b0;
        sd_buff_addr = '0;
        sd_buff_dout = '0;
        sd_buff_wr   = 1'b0;
        forever begin
            @(negedge clk30);
            if (sd_rd || sd_wr) serve_block(sd_wr, sd_lba[3:0]);
        end
    end

    // Monitor: every new block request is matched against the next expected one.
    initial begin
        bit prev_rd = 1'b0;
        bit prev_wr = 1'b0;
        forever begin
            @(negedge clk30);
            if ((sd_rd && !prev_rd) || (sd_wr && !prev_wr)) begin
                req_seen++;
                if (sd_wr) wr_seen++;
                if (req_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_request: got wr=%0d lba=%0d, expected no request", sd_wr, sd_lba);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    check_output("req_dir", 64'(sd_wr), 64'(r.wr));
                    check_output("req_lba", 64'(sd_lba), 64'(r.lba));
                    if (r.cyc >= 0) check_output("req_cycle", 64'(cyc), 64'(r.cyc));
                end
            end
            prev_rd = sd_rd;
            prev_wr = sd_wr;
        end
    end

    task automatic pulse_mount(input logic [63:0] size, input logic ro);
        @(negedge clk30);
        img_size     = size;
        img_readonly = ro;
        img_mounted  = 1'b1;
        @(negedge clk30);
        img_mounted  = 1'b0;
    endtask

    task automatic pulse_changed(output int at_cyc);
        @(negedge clk30);
        nvram_cpu_changed = 1'b1;
        at_cyc = cyc;
        @(negedge clk30);
        nvram_cpu_changed = 1'b0;
    endtask

    task automatic pulse_save();
        @(negedge clk30);
        save_req = 1'b1;
        @(negedge clk30);
        save_req = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = budget;
        while ((req_q.size() != 0 || busy || hps_active) && n > 0) begin
            @(negedge clk30);
            n--;
        end
        check_output({name, "_in_time"}, 64'(n > 0), 64'd1);
        check_output({name, "_drained"}, 64'(req_q.size()), 64'd0);
    endtask

    task automatic wait_req(input string name, input bit wr, input int lba);
        int n = 20000;
        do begin
            @(negedge clk30);
            n--;
        end while (!(((wr ? sd_wr : sd_rd) === 1'b1) && sd_lba == 32'(lba)) && n > 0);
        check_output({name, "_seen"}, 64'(n > 0), 64'd1);
    endtask

    initial begin
        int t;
        int n;
        int bad;
        int base;
        reset             = 1'b1;
        img_mounted       = 1'b0;
        img_readonly      = 1'b0;
        img_size          = '0;
        autosave_en       = 1'b1;
        save_req          = 1'b0;
        nvram_cpu_changed = 1'b0;
        repeat (4) @(negedge clk30);
        reset = 1'b0;
        @(negedge clk30);

        check_output("rst_sd_rd", 64'(sd_rd), 64'd0);
        check_output("rst_sd_wr", 64'(sd_wr), 64'd0);
        check_output("rst_sd_lba", 64'(sd_lba), 64'd0);
        check_output("rst_allow", 64'(nvram_allow_cpu_access), 64'd1);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_dirty", 64'(dut.dirty), 64'd0);

        $display("[TB] mount and restore");
        push_reqs(1'b0, 0, 15, -1);
        pulse_mount(64'd8192, 1'b0);
        n = 20;
        while (!busy && n > 0) begin @(negedge clk30); n--; end
        check_output("mount_busy_rise", 64'(busy), 64'd1);
        bad = 0;
        n = 20000;
        while (busy && n > 0) begin
            if (nvram_allow_cpu_access) bad++;
            @(negedge clk30);
            n--;
        end
        check_output("allow_low_during_restore", 64'(bad), 64'd0);
        check_output("allow_rise_cycle", 64'(cyc), 64'(last_ack_fall + 1));
        check_output("allow_after_restore", 64'(nvram_allow_cpu_access), 64'd1);
        wait_drain("restore", 1000);
        check_output("nvram_1a05", 64'(nvram[13'h1A05]), 64'h08);
        bad = 0;
        for (int a = 0; a < 8192; a++) if (nvram[a] !== exp_byte(4'(a >> 9), a)) bad++;
        check_output("nvram_image", 64'(bad), 64'd0);
        check_output("dirty_after_restore", 64'(dut.dirty), 64'd0);

        $display("[TB] debounced autosave");
        for (int k = 0; k < 3; k++) begin
            pulse_changed(t);
            if (k < 2) repeat (48) @(negedge clk30);
        end
        push_reqs(1'b1, 0, 15, t + DEB + 1);
        wait_drain("autosave", 20000);
        check_output("dirty_after_autosave", 64'(dut.dirty), 64'd0);

        $display("[TB] change during backup");
        push_reqs(1'b1, 0, 15, -1);
        pulse_changed(t);
        pulse_save();
        wait_req("blk7", 1'b1, 7);
        pulse_changed(t);
        push_reqs(1'b1, 0, 15, -1);
        wait_drain("double_backup", 40000);

        $display("[TB] remount during backup");
        push_reqs(1'b1, 0, 15, -1);
        push_reqs(1'b0, 0, 15, -1);
        pulse_changed(t);
        pulse_save();
        wait_req("blk3", 1'b1, 3);
        pulse_mount(64'd8192, 1'b0);
        wait_drain("remount", 40000);

        $display("[TB] read-only image");
        push_reqs(1'b0, 0, 15, -1);
        pulse_mount(64'd8192, 1'b1);
        wait_drain("ro_restore", 20000);
        base = wr_seen;
        pulse_changed(t);
        pulse_save();
        repeat (300) @(negedge clk30);
        check_output("ro_no_write", 64'(wr_seen - base), 64'd0);
        check_output("ro_dirty", 64'(dut.dirty), 64'd1);
        check_output("ro_busy", 64'(busy), 64'd0);

        $display("[TB] reset mid-restore");
        push_reqs(1'b0, 0, 5, -1);
        pulse_mount(64'd8192, 1'b0);
        wait_req("blk5", 1'b0, 5);
        reset = 1'b1;
        @(negedge clk30);
        check_output("abort_sd_rd", 64'(sd_rd), 64'd0);
        check_output("abort_sd_wr", 64'(sd_wr), 64'd0);
        check_output("abort_allow", 64'(nvram_allow_cpu_access), 64'd1);
        check_output("abort_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        base = req_seen;
        repeat (1500) @(negedge clk30);
        check_output("abort_no_requests", 64'(req_seen - base), 64'd0);
        check_output("abort_queue", 64'(req_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        repeat (98000) @(posedge clk30);
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
